// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder: MMIO register offsets,
// status/control bit positions, the bus word type and the decode select enum.
package mips_mem_pkg;

    typedef logic [31:0] word_t;

    // Offsets within the MMIO page; decode compares bits [7:2] only
    localparam logic [7:0] OFF_CON_DATA = 8'h00;
    localparam logic [7:0] OFF_CON_STAT = 8'h04;
    localparam logic [7:0] OFF_CYCLES   = 8'h08;
    localparam logic [7:0] OFF_TMR_CMP  = 8'h0C;
    localparam logic [7:0] OFF_TMR_CTRL = 8'h10;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_PENDING = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CON_DATA,
        SEL_CON_STAT,
        SEL_CYCLES,
        SEL_TMR_CMP,
        SEL_TMR_CTRL
    } sel_e;

    function automatic word_t pack_con_stat(logic [7:0] count, logic ovf,
                                            logic empty, logic full);
        word_t w;
        w = '0;
        w[STAT_COUNT_LSB +: 8] = count;
        w[STAT_OVF]            = ovf;
        w[STAT_EMPTY]          = empty;
        w[STAT_FULL]           = full;
        return w;
    endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// CPU data-memory port plus the console drain and interrupt lines of the responder.
interface mips_dmem_responder_if;
    import mips_mem_pkg::*;

    logic       memwrite;
    word_t      addr;
    word_t      writedata;
    word_t      readdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       irq;

    modport master (
        output memwrite, addr, writedata, tx_ready,
        input  readdata, tx_data, tx_valid, irq
    );

    modport slave (
        input  memwrite, addr, writedata, tx_ready,
        output readdata, tx_data, tx_valid, irq
    );

endinterface

// File: rtl/mips_console_fifo.sv
// Console TX FIFO: push from CPU stores, pop on valid/ready, sticky overflow flag.
// A push into a full FIFO is still accepted when a pop completes in the same cycle.
module mips_console_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     ready,
    input  logic                     ovf_clr,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = ready && !empty;
    assign push_ok = push && (!full || pop);
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) ovf <= 1'b1;
            else if (ovf_clr)     ovf <= 1'b0;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers define
    // what is valid, and a resettable array would cost a flop per bit.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the single-cycle MIPS: word RAM, console FIFO, cycle counter
// and compare timer. Define MIPS_DMEM_TIMER_EN to build TMR_CMP/TMR_CTRL and irq.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
    input logic                  clk,
    input logic                  reset,
    mips_dmem_responder_if.slave bus
);
    localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    sel_e              sel;
    logic              ram_hit;
    logic              mmio_hit;
    logic [RAM_AW-1:0] ram_idx;
    word_t             ram [RAM_WORDS];
    word_t             cycles;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_ovf;

    assign ram_hit  = ({1'b0, bus.addr} < RAM_BYTES);
    assign mmio_hit = (bus.addr[31:8] == MMIO_BASE[31:8]);
    assign ram_idx  = bus.addr[RAM_AW+1:2];

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        sel = SEL_NONE;
        if (ram_hit) begin
            sel = SEL_RAM;
        end else if (mmio_hit) begin
            case (bus.addr[7:2])
                OFF_CON_DATA[7:2]: sel = SEL_CON_DATA;
                OFF_CON_STAT[7:2]: sel = SEL_CON_STAT;
                OFF_CYCLES[7:2]:   sel = SEL_CYCLES;
`ifdef MIPS_DMEM_TIMER_EN
                OFF_TMR_CMP[7:2]:  sel = SEL_TMR_CMP;
                OFF_TMR_CTRL[7:2]: sel = SEL_TMR_CTRL;
`endif
                default:           sel = SEL_NONE;
            endcase
        end
    end

    logic ram_we;
    logic con_push;
    logic ovf_clr;

    assign ram_we   = bus.memwrite && (sel == SEL_RAM);
    assign con_push = bus.memwrite && (sel == SEL_CON_DATA);
    assign ovf_clr  = bus.memwrite && (sel == SEL_CON_STAT) && bus.writedata[STAT_OVF];

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= bus.writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycles <= '0;
        else       cycles <= cycles + 32'd1;
    end

    mips_console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (con_push),
        .din     (bus.writedata[7:0]),
        .ready   (bus.tx_ready),
        .ovf_clr (ovf_clr),
        .dout    (bus.tx_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .ovf     (fifo_ovf)
    );

    assign bus.tx_valid = !fifo_empty;

`ifdef MIPS_DMEM_TIMER_EN
    word_t tmr_cmp;
    logic  tmr_enable;
    logic  tmr_pending;
    logic  ctrl_we;

    assign ctrl_we = bus.memwrite && (sel == SEL_TMR_CTRL);

    // A compare hit in the same cycle as a clear-write leaves pending set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_cmp     <= '0;
            tmr_enable  <= 1'b0;
            tmr_pending <= 1'b0;
        end else begin
            if (bus.memwrite && (sel == SEL_TMR_CMP)) tmr_cmp <= bus.writedata;
            if (ctrl_we) tmr_enable <= bus.writedata[CTRL_ENABLE];
            if (tmr_enable && (cycles == tmr_cmp))
                tmr_pending <= 1'b1;
            else if (ctrl_we && bus.writedata[CTRL_PENDING])
                tmr_pending <= 1'b0;
        end
    end

    assign bus.irq = tmr_pending;
`else
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        bus.readdata = '0;
        case (sel)
            SEL_RAM:      bus.readdata = ram[ram_idx];
            SEL_CON_STAT: bus.readdata = pack_con_stat(8'(fifo_count), fifo_ovf,
                                                       fifo_empty, fifo_full);
            SEL_CYCLES:   bus.readdata = cycles;
`ifdef MIPS_DMEM_TIMER_EN
            SEL_TMR_CMP:  bus.readdata = tmr_cmp;
            SEL_TMR_CTRL: bus.readdata = {30'b0, tmr_pending, tmr_enable};
`endif
            default:      bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Randomised scoreboard bench for mips_dmem_responder against a queue/array reference model.
// Timer expectations follow MIPS_DMEM_TIMER_EN the same way the design does.
module tb_mips_dmem_responder;
    import mips_mem_pkg::*;

    localparam int          RAM_WORDS  = 64;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] MMIO       = 32'hFFFF0000;
`ifdef MIPS_DMEM_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mips_dmem_responder_if bus();

    mips_dmem_responder #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MMIO_BASE  (MMIO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    logic [31:0] m_ram [RAM_WORDS];
    logic [7:0]  m_fifo [$];
    bit          m_ovf;
    logic [31:0] m_cycles;
    logic [31:0] m_cmp;
    bit          m_en;
    bit          m_pend;

    typedef struct {
        logic [31:0] rd;
        logic        tv;
        logic [7:0]  td;
        logic        irq;
        string       tag;
    } exp_t;
    exp_t exp_q [$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int n;
        n = m_fifo.size();
        if (a < 32'(4 * RAM_WORDS)) return m_ram[a[7:2]];
        if (a[31:8] != MMIO[31:8]) return 32'h0;
        case (a[7:2])
            6'd1:    return {16'b0, 8'(n), 5'b0, m_ovf, n == 0, n == FIFO_DEPTH};
            6'd2:    return m_cycles;
            6'd3:    return TIMER ? m_cmp : 32'h0;
            6'd4:    return TIMER ? {30'b0, m_pend, m_en} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // State change caused by one rising edge with the given inputs applied
    task automatic advance(input bit mw, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        bit was_full, pop, hit, clr;
        was_full = (m_fifo.size() == FIFO_DEPTH);
        pop      = rdy && (m_fifo.size() != 0);
        hit      = m_en && (m_cycles == m_cmp);
        clr      = 1'b0;
        if (pop) void'(m_fifo.pop_front());
        if (mw && a < 32'(4 * RAM_WORDS)) begin
            m_ram[a[7:2]] = wd;
        end else if (mw && a[31:8] == MMIO[31:8]) begin
            case (a[7:2])
                6'd0: if (!was_full || pop) m_fifo.push_back(wd[7:0]); else m_ovf = 1'b1;
                6'd1: if (wd[2]) m_ovf = 1'b0;
                6'd3: if (TIMER) m_cmp = wd;
                6'd4: if (TIMER) begin m_en = wd[0]; clr = wd[1]; end
                default: ;
            endcase
        end
        if (hit) m_pend = 1'b1;
        else if (clr) m_pend = 1'b0;
        m_cycles = m_cycles + 32'd1;
    endtask

    task automatic step(input bit mw, input logic [31:0] a, input logic [31:0] wd,
                        input bit rdy, input bit rst, input string tag);
        exp_t e;
        @(negedge clk);
        #1;
        reset         = rst;
        bus.memwrite  = mw;
        bus.addr      = a;
        bus.writedata = wd;
        bus.tx_ready  = rdy;
        if (rst) begin
            m_fifo.delete();
            m_ovf = 0; m_cycles = '0; m_cmp = '0; m_en = 0; m_pend = 0;
        end
        e.rd  = model_read(a);
        e.tv  = (m_fifo.size() != 0);
        e.td  = e.tv ? m_fifo[0] : 8'h0;
        e.irq = TIMER ? m_pend : 1'b0;
        e.tag = tag;
        exp_q.push_back(e);
        if (!rst) advance(mw, a, wd, rdy);
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".readdata"}, bus.readdata, e.rd);
                check({e.tag, ".tx_valid"}, 32'(bus.tx_valid), 32'(e.tv));
                if (e.tv) check({e.tag, ".tx_data"}, 32'(bus.tx_data), 32'(e.td));
                check({e.tag, ".irq"}, 32'(bus.irq), 32'(e.irq));
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1, 2:    return 32'($urandom_range(0, 255));
            3, 4, 5, 6: return MMIO | 32'($urandom_range(0, 4) * 4 + $urandom_range(0, 3));
            7:          return MMIO | 32'($urandom_range(8'h18, 8'hFF));
            8:          return 32'h0000_1000 + 32'($urandom_range(0, 4095));
            default:    return 32'h8000_0000 | 32'($urandom);
        endcase
    endfunction

    localparam logic [31:0] A_DATA = MMIO | 32'(OFF_CON_DATA);
    localparam logic [31:0] A_STAT = MMIO | 32'(OFF_CON_STAT);
    localparam logic [31:0] A_CYC  = MMIO | 32'(OFF_CYCLES);
    localparam logic [31:0] A_CMP  = MMIO | 32'(OFF_TMR_CMP);
    localparam logic [31:0] A_CTRL = MMIO | 32'(OFF_TMR_CTRL);

    initial begin
        logic [31:0] a, wd;
        bit mw;
        bus.memwrite = 1'b0; bus.addr = A_CYC; bus.writedata = '0; bus.tx_ready = 1'b0;

        step(0, A_CYC, 0, 0, 1, "reset");
        step(0, A_STAT, 0, 0, 1, "reset_stat");
        step(0, A_CYC, 0, 0, 0, "release");
        for (int i = 0; i < RAM_WORDS; i++) step(1, 32'(i * 4), $urandom, 0, 0, "ram_init");

        // RAM write/readback, neighbour untouched
        step(1, 32'h10, 32'hDEADBEEF, 0, 0, "ram_wr");
        step(0, 32'h10, 0, 0, 0, "ram_rd");
        step(0, 32'h14, 0, 0, 0, "ram_rd_next");

        // Overfill with sink stalled, then drain in order and clear overflow
        for (int i = 0; i < 9; i++) step(1, A_DATA, 32'(8'h41 + i), 0, 0, "fill");
        step(0, A_STAT, 0, 0, 0, "stat_full");
        for (int i = 0; i < 10; i++) step(0, A_STAT, 0, 1, 0, "drain");
        step(1, A_STAT, 32'h4, 0, 0, "ovf_clr");
        step(0, A_STAT, 0, 0, 0, "stat_clr");

        // Push into a full FIFO while it pops
        for (int i = 0; i < 8; i++) step(1, A_DATA, 32'(8'h61 + i), 0, 0, "fill2");
        step(1, A_DATA, 32'h7A, 1, 0, "push_pop_full");
        step(0, A_STAT, 0, 0, 0, "stat_pp");
        for (int i = 0; i < 9; i++) step(0, A_DATA, 0, 1, 0, "drain2");

        // Timer compare at 20 after reset, then clear
        step(0, A_CYC, 0, 0, 1, "tmr_reset");
        step(1, A_CMP, 32'd20, 0, 0, "tmr_cmp");
        step(1, A_CTRL, 32'd1, 0, 0, "tmr_en");
        for (int i = 0; i < 22; i++) step(0, A_CTRL, 0, 0, 0, "tmr_wait");
        step(1, A_CTRL, 32'd3, 0, 0, "tmr_clr");
        step(0, A_CTRL, 0, 0, 0, "tmr_after_clr");

        // Compare register readback (0 when the timer is built out)
        step(1, A_CMP, 32'd5, 0, 0, "cmp_wr");
        step(0, A_CMP, 0, 0, 0, "cmp_rd");
        for (int i = 0; i < 64; i++) step(0, A_CYC, 0, 0, 0, "idle");

        // Reset mid-drain with bytes queued; RAM survives
        for (int i = 0; i < 3; i++) step(1, A_DATA, 32'(8'h30 + i), 0, 0, "pre_rst");
        step(0, A_STAT, 0, 1, 0, "drain_one");
        step(0, A_CYC, 0, 1, 1, "mid_reset");
        step(0, A_STAT, 0, 1, 1, "mid_reset_stat");
        step(0, 32'h10, 0, 0, 0, "ram_after_rst");

        for (int i = 0; i < 2000; i++) begin
            a  = rand_addr();
            mw = ($urandom_range(0, 2) == 0);
            wd = $urandom;
            if (a[31:8] == MMIO[31:8] && a[7:2] == 6'd3) wd = m_cycles + 32'($urandom_range(1, 6));
            if (a[31:8] == MMIO[31:8] && a[7:2] == 6'd4) wd = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) step(0, a, wd, $urandom_range(0, 1), 1, "rnd_rst");
            else step(mw, a, wd, ($urandom_range(0, 2) != 0), 0, "rnd");
        end

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
